instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
CPU-side instruction fetch unit. It turns the CPU's 32-bit PC into byte-wide read transactions on the instruction memory port and assembles four bytes into a 32-bit little-endian instruction. It asserts BUSYWAIT to stall the CPU until the instruction is valid. It sits between the cpu core's PC/INSTRUCTION pins and a byte-organised 1024-entry instruction memory with a read/acknowledge handshake.

Parameters:
ADDR_W, 10, memory byte-address width (1024 bytes).
NOP_INSTR, 32'h0000_0000, instruction driven on a fetch error.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RESET  in  1  asynchronous, active-low reset.
PC  in  32  fetch address from the CPU.
INSTRUCTION  out  32  assembled instruction; registered.
BUSYWAIT  out  1  high while INSTRUCTION does not correspond to the current PC.
FETCH_ERR  out  1  high when the current PC is misaligned or out of range; registered.
MEM_READ  out  1  byte read request; registered.
MEM_ADDRESS  out  ADDR_W  byte address of the current request; registered.
MEM_READDATA  in  8  byte returned by memory; valid when MEM_ACK=1.
MEM_ACK  in  1  memory has returned MEM_READDATA for MEM_ADDRESS; sampled on the rising edge.

Behaviour:
- RESET low (asynchronous) sets:
  - state=IDLE, valid=0, tag=0, byte counter k=0
  - INSTRUCTION=0, MEM_READ=0, MEM_ADDRESS=0, FETCH_ERR=0
- BUSYWAIT is combinational and equals NOT(valid AND PC==tag AND state==IDLE). It is therefore 1 during reset.
- States:
  - IDLE: no request.
  - REQ: byte fetch in progress; k in 0..3.
- IDLE with a hit (valid AND PC==tag): hold all outputs; issue no request.
- IDLE with a miss, on the next edge:
  - If PC[1:0]!=0 or PC[31:ADDR_W]!=0: INSTRUCTION=NOP_INSTR, FETCH_ERR=1, tag=PC, valid=1, stay IDLE. No memory access occurs.
  - Otherwise: FETCH_ERR=0, base=PC, k=0, MEM_READ=1, MEM_ADDRESS=PC[ADDR_W-1:0], go to REQ.
- REQ, edge with MEM_ACK=1:
  - Place MEM_READDATA into assembly bits [8k+7:8k].
  - If k<3: k++ and MEM_ADDRESS=base+k+1. MEM_READ stays high.
  - If k==3: INSTRUCTION=assembled word, tag=base, valid=1, MEM_READ=0, go to IDLE.
- REQ, edge with MEM_ACK=0: hold MEM_ADDRESS and MEM_READ. The address must stay stable until acknowledged.
- PC changes while in REQ:
  - The outstanding byte is never aborted; wait for its MEM_ACK.
  - On that ACK edge, discard the partial word, set valid=0, and return to IDLE. The next edge starts the new PC as a miss.
  - INSTRUCTION keeps its old value until a complete word arrives.
- MEM_ACK while MEM_READ=0: ignored.
- Latency: with a zero-wait memory (MEM_ACK=1 in every REQ cycle), BUSYWAIT falls 5 rising edges after the miss is seen. Each memory wait cycle adds one edge.
- Byte order is little-endian: byte at base+0 goes to bits [7:0], byte at base+3 goes to bits [31:24].
- Address arithmetic is ADDR_W bits wide. No wrap occurs, because the aligned, in-range check guarantees base+3 ≤ 2^ADDR_W−1.
- RESET asserted mid-fetch: MEM_READ drops immediately and the partial word is lost. After release, the current PC is refetched.

Decomposition:
- Shared package cpu_fetch_pkg:
  - fetch state enum (IDLE, REQ)
  - BYTES_PER_INSTR=4
  - NOP_INSTR default
- One natural sub-module: instr_byte_assembler.
  - Contents: 32-bit assembly register and 2-bit byte counter.
  - Inputs: load-byte, clear.
  - Output: done-on-byte-3.
- The top level holds the FSM, tag/valid and the BUSYWAIT logic.
- The bench provides a byte memory model with a configurable ACK wait count.

Test Plan:
1. Bytes 0x05,0x00,0x04,0x00 at addresses 0..3; zero-wait memory; release RESET with PC=0 → MEM_ADDRESS sequence 0,1,2,3; INSTRUCTION=0x00040005; BUSYWAIT low on the 5th edge after release.
2. PC held at 0 for 10 cycles after test 1 → MEM_READ stays 0; BUSYWAIT stays 0; INSTRUCTION unchanged.
3. Bytes 0x09,0x00,0x02,0x00 at addresses 4..7; PC 0→4 with 2 wait cycles per byte → INSTRUCTION=0x00020009; BUSYWAIT high for 13 edges.
4. PC changes from 4 to 8 after byte 1 is acknowledged, with byte 2 outstanding → byte 2 at address 6 still completes; then addresses 8..11 are fetched; INSTRUCTION is the word at 8; 0x00020009 is never replaced by a partial word.
5. PC=0x0000_0002, then PC=0x0000_0400 → no MEM_READ; FETCH_ERR=1; INSTRUCTION=0x00000000; BUSYWAIT low after 1 edge.
6. RESET pulled low during byte 2 of a fetch → MEM_READ=0 and INSTRUCTION=0 immediately, without waiting for a clock edge; after release the same PC is fully refetched.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the CPU instruction fetch path.
package cpu_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  localparam int BYTES_PER_INSTR = 4;
  localparam int BYTE_IDX_W = $clog2(BYTES_PER_INSTR);
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Byte-wide instruction memory port between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10
) ();
  // Handshake: MEM_READ/MEM_ADDRESS are held stable until an edge with MEM_ACK=1,
  // which transfers MEM_READDATA for that address; MEM_ACK with MEM_READ=0 is ignored.
  logic              MEM_READ;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [7:0]        MEM_READDATA;
  logic              MEM_ACK;

  modport master (
    output MEM_READ,
    output MEM_ADDRESS,
    input  MEM_READDATA,
    input  MEM_ACK
  );

  modport slave (
    input  MEM_READ,
    input  MEM_ADDRESS,
    output MEM_READDATA,
    output MEM_ACK
  );
endinterface

// File: rtl/instr_byte_assembler.sv
// Collects four little-endian bytes into a 32-bit word; done_o flags the final byte.
module instr_byte_assembler
  import cpu_fetch_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic [7:0]            byte_i,
  output logic [BYTE_IDX_W-1:0] k_o,
  output logic [31:0]           word_o,
  output logic                  done_o
);

  logic [BYTE_IDX_W-1:0] k_q;
  logic [31:0]           asm_q;

  assign k_o    = k_q;
  assign done_o = load_i && (k_q == BYTE_IDX_W'(BYTES_PER_INSTR - 1));

  // Word as it will look once the byte on byte_i lands in its lane.
  always_comb begin
    word_o = asm_q;
    word_o[{k_q, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q   <= '0;
      asm_q <= '0;
    end else if (clr_i) begin
      k_q   <= '0;
      asm_q <= '0;
    end else if (load_i) begin
      asm_q[{k_q, 3'b000} +: 8] <= byte_i;
      k_q                      <= k_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: turns the CPU PC into four byte reads and stalls the CPU via BUSYWAIT.
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         PC,
  output logic [31:0]         INSTRUCTION,
  output logic                BUSYWAIT,
  output logic                FETCH_ERR,
  instr_fetch_unit_if.master  mem,
  output fetch_state_e        dbg_state_o
);

  fetch_state_e      state_q;
  logic              valid_q;
  logic [31:0]       tag_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q;
  logic              err_q;

  logic                  hit;
  logic                  pc_bad;
  logic                  pc_moved;
  logic                  byte_ld;
  logic                  asm_clr;
  logic                  asm_done;
  logic [BYTE_IDX_W-1:0] k;
  logic [31:0]           asm_word;

  assign hit      = valid_q && (PC == tag_q);
  assign pc_bad   = (PC[1:0] != 2'b00) || (PC[31:ADDR_W] != '0);
  assign pc_moved = (PC != {{(32-ADDR_W){1'b0}}, base_q});
  assign byte_ld  = (state_q == REQ) && mem.MEM_ACK;
  // A PC change is only acted on when the outstanding byte is acknowledged.
  assign asm_clr  = byte_ld && pc_moved;

  assign BUSYWAIT        = !(hit && (state_q == IDLE));
  assign INSTRUCTION     = instr_q;
  assign FETCH_ERR       = err_q;
  assign mem.MEM_READ    = read_q;
  assign mem.MEM_ADDRESS = addr_q;
  assign dbg_state_o     = state_q;

  instr_byte_assembler u_asm (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .load_i (byte_ld),
    .clr_i  (asm_clr),
    .byte_i (mem.MEM_READDATA),
    .k_o    (k),
    .word_o (asm_word),
    .done_o (asm_done)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      instr_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            if (pc_bad) begin
              instr_q <= NOP_INSTR;
              err_q   <= 1'b1;
              tag_q   <= PC;
              valid_q <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              base_q  <= PC[ADDR_W-1:0];
              addr_q  <= PC[ADDR_W-1:0];
              read_q  <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (byte_ld) begin
            if (pc_moved) begin
              valid_q <= 1'b0;
              read_q  <= 1'b0;
              state_q <= IDLE;
            end else if (asm_done) begin
              instr_q <= asm_word;
              tag_q   <= {{(32-ADDR_W){1'b0}}, base_q};
              valid_q <= 1'b1;
              read_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              addr_q <= base_q + ADDR_W'(k) + ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte memory model and configurable ACK wait.
module tb_instr_fetch_unit;
  import cpu_fetch_pkg::*;

  localparam int ADDR_W = 10;

  // ---------------- clock / reset ----------------
  logic         CLK   = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  PC    = 32'h0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         FETCH_ERR;
  fetch_state_e dbg_state;

  always #5 CLK = ~CLK;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) mem_if ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .NOP_INSTR(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .FETCH_ERR   (FETCH_ERR),
    .mem         (mem_if.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [7:0]        mem [0:1023];
  int                wait_cycles = 0;
  int                wait_cnt    = 0;
  logic [ADDR_W-1:0] got_q[$];
  logic [ADDR_W-1:0] exp_q[$];

  initial begin
    mem_if.MEM_ACK      = 1'b0;
    mem_if.MEM_READDATA = 8'h00;
    forever begin
      @(negedge CLK);
      if (!RESET || !mem_if.MEM_READ) begin
        mem_if.MEM_ACK = 1'b0;
        wait_cnt       = 0;
      end else begin
        if (mem_if.MEM_ACK) wait_cnt = 0;
        if (wait_cnt >= wait_cycles) begin
          mem_if.MEM_ACK      = 1'b1;
          mem_if.MEM_READDATA = mem[mem_if.MEM_ADDRESS];
          got_q.push_back(mem_if.MEM_ADDRESS);
        end else begin
          mem_if.MEM_ACK = 1'b0;
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_addrs(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(ADDR_W'(first + i));
  endtask

  task automatic check_addrs(input string tag);
    logic [ADDR_W-1:0] e;
    logic [ADDR_W-1:0] g;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      chk({tag, "_addr"}, 32'(g), 32'(e));
    end
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      @(posedge CLK);
      #1;
      edges++;
    end while (BUSYWAIT && edges < 400);
  endtask

  task automatic wait_acked(input int n, input string tag);
    int i;
    i = 0;
    while (got_q.size() < n && i < 200) begin
      @(negedge CLK);
      #1;
      i++;
    end
    chk(tag, 32'(got_q.size() >= n), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int   edges;
  int   bad;
  logic [31:0] held;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    {mem[3], mem[2], mem[1], mem[0]}     = 32'h0004_0005;
    {mem[7], mem[6], mem[5], mem[4]}     = 32'h0002_0009;
    {mem[11], mem[10], mem[9], mem[8]}   = 32'h4433_2211;
    {mem[15], mem[14], mem[13], mem[12]} = 32'hDEAD_BEEF;

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_instr",    INSTRUCTION, 32'h0);
    chk("rst_mem_read", 32'(mem_if.MEM_READ), 32'd0);
    chk("rst_mem_addr", 32'(mem_if.MEM_ADDRESS), 32'd0);
    chk("rst_fetch_err", 32'(FETCH_ERR), 32'd0);
    chk("rst_busy",     32'(BUSYWAIT), 32'd1);
    chk("rst_state",    32'(dbg_state), 32'(IDLE));

    // 1: zero-wait fetch of PC=0 straight out of reset
    wait_cycles = 0;
    got_q.delete();
    RESET = 1'b1;
    wait_ready(edges);
    chk("t1_latency", 32'(edges), 32'd5);
    chk("t1_instr", INSTRUCTION, 32'h0004_0005);
    chk("t1_err", 32'(FETCH_ERR), 32'd0);
    expect_addrs(0, 4);
    check_addrs("t1");

    // 2: hit holds everything
    bad = 0;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (mem_if.MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0 || INSTRUCTION !== 32'h0004_0005) bad++;
    end
    chk("t2_hold_bad_cycles", 32'(bad), 32'd0);
    chk("t2_no_reads", 32'(got_q.size()), 32'd0);

    // 3: two wait cycles per byte
    wait_cycles = 2;
    PC = 32'h4;
    wait_ready(edges);
    chk("t3_latency", 32'(edges), 32'd13);
    chk("t3_instr", INSTRUCTION, 32'h0002_0009);
    expect_addrs(4, 4);
    check_addrs("t3");

    // 4: PC moves to 8 while byte 2 of address 4 is outstanding
    wait_cycles = 0;
    PC = 32'h0;
    wait_ready(edges);
    chk("t4_pre_instr", INSTRUCTION, 32'h0004_0005);
    expect_addrs(0, 4);
    check_addrs("t4_pre");
    wait_cycles = 2;
    PC = 32'h4;
    wait_acked(2, "t4_wait_byte1");
    @(posedge CLK);
    #1;
    PC   = 32'h8;
    held = INSTRUCTION;
    bad  = 0;
    edges = 0;
    do begin
      @(posedge CLK);
      #1;
      edges++;
      if (BUSYWAIT && INSTRUCTION !== held) bad++;
    end while (BUSYWAIT && edges < 400);
    chk("t4_no_partial", 32'(bad), 32'd0);
    chk("t4_latency", 32'(edges), 32'd16);
    chk("t4_instr", INSTRUCTION, 32'h4433_2211);
    expect_addrs(4, 3);
    expect_addrs(8, 4);
    check_addrs("t4");

    // 5: misaligned and out-of-range PCs
    PC = 32'h0000_0002;
    #1;
    chk("t5a_busy_now", 32'(BUSYWAIT), 32'd1);
    wait_ready(edges);
    chk("t5a_latency", 32'(edges), 32'd1);
    chk("t5a_err", 32'(FETCH_ERR), 32'd1);
    chk("t5a_instr", INSTRUCTION, 32'h0);
    chk("t5a_read", 32'(mem_if.MEM_READ), 32'd0);
    PC = 32'h0000_0400;
    wait_ready(edges);
    chk("t5b_latency", 32'(edges), 32'd1);
    chk("t5b_err", 32'(FETCH_ERR), 32'd1);
    chk("t5b_instr", INSTRUCTION, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("t5_read_idle", 32'(mem_if.MEM_READ), 32'd0);
    chk("t5_no_reads", 32'(got_q.size()), 32'd0);

    // 6: reset in the middle of a fetch
    wait_cycles = 0;
    PC = 32'h8;
    wait_ready(edges);
    chk("t6_pre_err", 32'(FETCH_ERR), 32'd0);
    chk("t6_pre_instr", INSTRUCTION, 32'h4433_2211);
    got_q.delete();
    wait_cycles = 1;
    PC = 32'hC;
    wait_acked(2, "t6_wait_byte1");
    @(posedge CLK);
    #1;
    chk("t6_read_before", 32'(mem_if.MEM_READ), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("t6_rst_read", 32'(mem_if.MEM_READ), 32'd0);
    chk("t6_rst_instr", INSTRUCTION, 32'h0);
    chk("t6_rst_busy", 32'(BUSYWAIT), 32'd1);
    chk("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK);
    got_q.delete();
    RESET = 1'b1;
    wait_ready(edges);
    chk("t6_latency", 32'(edges), 32'd9);
    chk("t6_instr", INSTRUCTION, 32'hDEAD_BEEF);
    expect_addrs(12, 4);
    check_addrs("t6");

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
